// File: rtl/jtag_pkg.sv
// Shared types and constants for the s9234 boundary-scan TAP controller.
package jtag_pkg;

    localparam int IR_WIDTH = 2;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 2'b01;
    localparam logic [IR_WIDTH-1:0] IR_RESET   = 2'b11;

    localparam logic [IR_WIDTH-1:0] INST_EXTEST = 2'b00;
    localparam logic [IR_WIDTH-1:0] INST_SAMPLE = 2'b01;
    localparam logic [IR_WIDTH-1:0] INST_INTEST = 2'b10;
    localparam logic [IR_WIDTH-1:0] INST_BYPASS = 2'b11;

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_t;

    // BSR cells drive the core/pins only for EXTEST and INTEST.
    function automatic logic is_drive_mode(input logic [IR_WIDTH-1:0] inst);
        return (inst == INST_EXTEST) || (inst == INST_INTEST);
    endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// Serial scan and BSR-control signals between the scan driver and the TAP.
interface jtag_tap_if;
    import jtag_pkg::*;

    logic                TMS;
    logic                TDI;
    logic                bsr_tdo;
    logic                TDO;
    logic                tdo_en;
    logic [IR_WIDTH-1:0] inst;
    logic [3:0]          tap_state;
    logic                bsr_capture;
    logic                bsr_shift;
    logic                bsr_update;
    logic                bsr_mode;

    modport slave (
        input  TMS, TDI, bsr_tdo,
        output TDO, tdo_en, inst, tap_state,
        output bsr_capture, bsr_shift, bsr_update, bsr_mode
    );

    modport master (
        output TMS, TDI, bsr_tdo,
        input  TDO, tdo_en, inst, tap_state,
        input  bsr_capture, bsr_shift, bsr_update, bsr_mode
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: state register plus next-state decode.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tclk,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_next_state
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) r_state <= ST_TLR;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = ST_TLR;
        case (r_state)
            ST_TLR:      w_next = i_tms ? ST_TLR      : ST_RTI;
            ST_RTI:      w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_next = i_tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_next = i_tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    w_next = i_tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   w_next = i_tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next = i_tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   w_next = i_tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_next = i_tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_next = i_tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    w_next = i_tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   w_next = i_tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next = i_tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   w_next = i_tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
            default:     w_next = ST_TLR;
        endcase
    end

    assign o_state      = r_state;
    assign o_next_state = w_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction/bypass registers, BSR control decode and
// the falling-edge TDO mux around the TAP state machine.
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic        TCLK,
    input  logic        TRST,
    jtag_tap_if.slave   bus
);

    tap_state_t          w_state;
    tap_state_t          w_next_state;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_inst;
    logic                r_bypass;
    logic                r_tdo;
    logic                r_tdo_en;
    logic                w_is_bypass;
    logic                w_tdo_src;
    logic                w_tdo_valid;

    jtag_tap_fsm u_fsm (
        .i_tclk       (TCLK),
        .i_trst_n     (TRST),
        .i_tms        (bus.TMS),
        .o_state      (w_state),
        .o_next_state (w_next_state)
    );

    assign w_is_bypass = (r_inst == INST_BYPASS);

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_ir_shift <= IR_CAPTURE;
            r_inst     <= IR_RESET;
            r_bypass   <= 1'b0;
        end else begin
            if (w_state == ST_CAP_IR)
                r_ir_shift <= IR_CAPTURE;
            else if (w_state == ST_SH_IR)
                r_ir_shift <= {bus.TDI, r_ir_shift[IR_WIDTH-1:1]};

            // Forcing on entry keeps inst at BYPASS for every cycle spent in TLR.
            if (w_next_state == ST_TLR)
                r_inst <= IR_RESET;
            else if (w_state == ST_UPD_IR)
                r_inst <= r_ir_shift;

            if (w_state == ST_CAP_DR)
                r_bypass <= 1'b0;
            else if ((w_state == ST_SH_DR) && w_is_bypass)
                r_bypass <= bus.TDI;
        end
    end

    always_comb begin
        w_tdo_src   = 1'b0;
        w_tdo_valid = 1'b0;
        case (w_state)
            ST_SH_IR: begin
                w_tdo_src   = r_ir_shift[0];
                w_tdo_valid = 1'b1;
            end
            ST_SH_DR: begin
                w_tdo_src   = w_is_bypass ? r_bypass : bus.bsr_tdo;
                w_tdo_valid = 1'b1;
            end
            default: begin
                w_tdo_src   = 1'b0;
                w_tdo_valid = 1'b0;
            end
        endcase
    end

    // TDO launches on the falling edge so the driver can sample it on the next rise.
    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_src;
            r_tdo_en <= w_tdo_valid;
        end
    end

    assign bus.TDO         = r_tdo;
    assign bus.tdo_en      = r_tdo_en;
    assign bus.inst        = r_inst;
    assign bus.tap_state   = w_state;
    assign bus.bsr_capture = (w_state == ST_CAP_DR) && !w_is_bypass;
    assign bus.bsr_shift   = (w_state == ST_SH_DR)  && !w_is_bypass;
    assign bus.bsr_update  = (w_state == ST_UPD_DR) && !w_is_bypass;
    assign bus.bsr_mode    = is_drive_mode(r_inst);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed-vector bench for jtag_tap_ctrl: reset, TLR recovery, IR load,
// bypass path, SAMPLE/PRELOAD BSR shifting and asynchronous TRST mid-shift.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic tclk = 1'b0;
    logic trst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    jtag_tap_if bus_if();

    jtag_tap_ctrl dut (
        .TCLK (tclk),
        .TRST (trst),
        .bus  (bus_if)
    );

    always #5 tclk = ~tclk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Called just after a falling edge; returns just after the next falling
    // edge, so state reflects the rise and TDO the fall that followed it.
    task automatic tick(input logic tms, input logic tdi, input logic bsr);
        bus_if.TMS     = tms;
        bus_if.TDI     = tdi;
        bus_if.bsr_tdo = bsr;
        @(posedge tclk);
        @(negedge tclk);
        #1;
        $display("tick tms=%b tdi=%b bsr_tdo=%b -> state=%h inst=%b tdo=%b en=%b cap=%b sh=%b upd=%b mode=%b",
                 tms, tdi, bsr, bus_if.tap_state, bus_if.inst, bus_if.TDO, bus_if.tdo_en,
                 bus_if.bsr_capture, bus_if.bsr_shift, bus_if.bsr_update, bus_if.bsr_mode);
    endtask

    task automatic test_reset();
        bus_if.TMS = 1'b1; bus_if.TDI = 1'b0; bus_if.bsr_tdo = 1'b0;
        trst = 1'b0;
        repeat (3) @(negedge tclk);
        #1;
        checks++; if (bus_if.tap_state !== 4'hF) begin errors++; $display("FAIL reset_state got=%h exp=F", bus_if.tap_state); end
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL reset_inst got=%b exp=11", bus_if.inst); end
        checks++; if (bus_if.TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo got=%b exp=0", bus_if.TDO); end
        checks++; if (bus_if.tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo_en got=%b exp=0", bus_if.tdo_en); end
        checks++; if ({bus_if.bsr_capture, bus_if.bsr_shift, bus_if.bsr_update, bus_if.bsr_mode} !== 4'b0000) begin
            errors++; $display("FAIL reset_bsr got=%b exp=0000", {bus_if.bsr_capture, bus_if.bsr_shift, bus_if.bsr_update, bus_if.bsr_mode});
        end
        trst = 1'b1;
        #1;
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.tap_state !== 4'hC) begin errors++; $display("FAIL reset_to_rti got=%h exp=C", bus_if.tap_state); end
        $display("test_reset done");
    endtask

    task automatic test_tlr_from_any();
        // RTI -> SelDR -> CapDR -> ShDR
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.tap_state !== 4'h2) begin errors++; $display("FAIL reach_shdr got=%h exp=2", bus_if.tap_state); end
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.tap_state !== 4'hF) begin errors++; $display("FAIL tlr_from_shdr got=%h exp=F", bus_if.tap_state); end
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL tlr_from_shdr_inst got=%b exp=11", bus_if.inst); end
        // TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR -> Ex1IR (stage now 00) -> PauseIR
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (bus_if.tap_state !== 4'hB) begin errors++; $display("FAIL reach_pauseir got=%h exp=B", bus_if.tap_state); end
        checks++; if (bus_if.tdo_en !== 1'b0) begin errors++; $display("FAIL pauseir_tdo_en got=%b exp=0", bus_if.tdo_en); end
        // Path passes through UpdIR (loads 00) before landing in TLR.
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        checks++; if (bus_if.tap_state !== 4'hF) begin errors++; $display("FAIL tlr_from_pauseir got=%h exp=F", bus_if.tap_state); end
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL tlr_from_pauseir_inst got=%b exp=11", bus_if.inst); end
        $display("test_tlr_from_any done");
    endtask

    task automatic test_ir_load();
        tick(1'b0, 1'b0, 1'b0);   // RTI
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        tick(1'b1, 1'b0, 1'b0);   // SelIR
        tick(1'b0, 1'b0, 1'b0);   // CapIR
        checks++; if (bus_if.tap_state !== 4'hE) begin errors++; $display("FAIL reach_capir got=%h exp=E", bus_if.tap_state); end
        tick(1'b0, 1'b0, 1'b0);   // ShIR, capture loaded
        checks++; if (bus_if.tap_state !== 4'hA) begin errors++; $display("FAIL reach_shir got=%h exp=A", bus_if.tap_state); end
        checks++; if ({bus_if.tdo_en, bus_if.TDO} !== 2'b11) begin errors++; $display("FAIL ir_tdo_bit0 got=%b exp=11 (en,tdo)", {bus_if.tdo_en, bus_if.TDO}); end
        tick(1'b0, 1'b0, 1'b0);   // shift TDI=0, stay ShIR
        checks++; if ({bus_if.tdo_en, bus_if.TDO} !== 2'b10) begin errors++; $display("FAIL ir_tdo_bit1 got=%b exp=10 (en,tdo)", {bus_if.tdo_en, bus_if.TDO}); end
        tick(1'b1, 1'b1, 1'b0);   // shift TDI=1, to Ex1IR
        checks++; if (bus_if.tdo_en !== 1'b0) begin errors++; $display("FAIL ex1ir_tdo_en got=%b exp=0", bus_if.tdo_en); end
        tick(1'b1, 1'b0, 1'b0);   // UpdIR
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL inst_before_upd_exit got=%b exp=11", bus_if.inst); end
        tick(1'b0, 1'b0, 1'b0);   // RTI, inst updated
        checks++; if (bus_if.inst !== 2'b10) begin errors++; $display("FAIL ir_load_inst got=%b exp=10", bus_if.inst); end
        checks++; if (bus_if.bsr_mode !== 1'b1) begin errors++; $display("FAIL intest_mode got=%b exp=1", bus_if.bsr_mode); end
        $display("test_ir_load done");
    endtask

    task automatic test_bypass();
        logic [3:0] pattern;
        pattern = 4'b1101;        // applied bit0 first: 1,0,1,1
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);   // RTI with inst=BYPASS
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        tick(1'b0, 1'b0, 1'b1);   // CapDR
        checks++; if (bus_if.bsr_capture !== 1'b0) begin errors++; $display("FAIL bypass_capture got=%b exp=0", bus_if.bsr_capture); end
        tick(1'b0, 1'b0, 1'b1);   // ShDR
        checks++; if ({bus_if.tdo_en, bus_if.TDO} !== 2'b10) begin errors++; $display("FAIL bypass_lead got=%b exp=10 (en,tdo)", {bus_if.tdo_en, bus_if.TDO}); end
        checks++; if (bus_if.bsr_shift !== 1'b0) begin errors++; $display("FAIL bypass_shift0 got=%b exp=0", bus_if.bsr_shift); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, pattern[i], ~pattern[i]);
            checks++; if (bus_if.TDO !== pattern[i]) begin errors++; $display("FAIL bypass_bit%0d got=%b exp=%b", i, bus_if.TDO, pattern[i]); end
            checks++; if (bus_if.bsr_shift !== 1'b0) begin errors++; $display("FAIL bypass_shift%0d got=%b exp=0", i + 1, bus_if.bsr_shift); end
        end
        tick(1'b1, 1'b0, 1'b0);   // Ex1DR
        checks++; if (bus_if.tdo_en !== 1'b0) begin errors++; $display("FAIL bypass_ex1_en got=%b exp=0", bus_if.tdo_en); end
        tick(1'b1, 1'b0, 1'b0);   // UpdDR
        checks++; if (bus_if.bsr_update !== 1'b0) begin errors++; $display("FAIL bypass_update got=%b exp=0", bus_if.bsr_update); end
        tick(1'b0, 1'b0, 1'b0);   // RTI
        $display("test_bypass done");
    endtask

    task automatic test_bsr_sample();
        logic [35:0] bsr_pat;
        int          shift_cycles;
        int          update_pulses;
        bsr_pat = 36'h9A5C31E7B;
        shift_cycles = 0;
        update_pulses = 0;
        // Load IR=01: shift TDI 1 then 0.
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        tick(1'b1, 1'b0, 1'b0);   // SelIR
        tick(1'b0, 1'b0, 1'b0);   // CapIR
        tick(1'b0, 1'b0, 1'b0);   // ShIR
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);   // Ex1IR
        tick(1'b1, 1'b0, 1'b0);   // UpdIR
        tick(1'b0, 1'b0, 1'b0);   // RTI
        checks++; if (bus_if.inst !== 2'b01) begin errors++; $display("FAIL sample_inst got=%b exp=01", bus_if.inst); end
        checks++; if (bus_if.bsr_mode !== 1'b0) begin errors++; $display("FAIL sample_mode got=%b exp=0", bus_if.bsr_mode); end
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        tick(1'b0, 1'b0, 1'b0);   // CapDR
        checks++; if (bus_if.bsr_capture !== 1'b1) begin errors++; $display("FAIL sample_capture got=%b exp=1", bus_if.bsr_capture); end
        for (int i = 0; i < 37; i++) begin
            // i=0 enters ShDR; i=1..35 stay; i=36 leaves to Ex1DR
            tick((i == 36) ? 1'b1 : 1'b0, 1'b0, (i < 36) ? bsr_pat[i] : 1'b0);
            if (bus_if.bsr_shift === 1'b1) shift_cycles++;
            if (bus_if.bsr_update === 1'b1) update_pulses++;
            if (i < 36) begin
                checks++; if (bus_if.TDO !== bsr_pat[i]) begin errors++; $display("FAIL bsr_tdo_follow%0d got=%b exp=%b", i, bus_if.TDO, bsr_pat[i]); end
            end
        end
        checks++; if (shift_cycles != 36) begin errors++; $display("FAIL bsr_shift_cycles got=%0d exp=36", shift_cycles); end
        tick(1'b1, 1'b0, 1'b0);   // UpdDR
        checks++; if (bus_if.bsr_update !== 1'b1) begin errors++; $display("FAIL bsr_update_in_upd got=%b exp=1", bus_if.bsr_update); end
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        tick(1'b0, 1'b0, 1'b0);   // RTI
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        checks++; if (update_pulses != 1) begin errors++; $display("FAIL bsr_update_pulses got=%0d exp=1", update_pulses); end
        checks++; if (bus_if.tap_state !== 4'hC) begin errors++; $display("FAIL sample_end_state got=%h exp=C", bus_if.tap_state); end
        $display("test_bsr_sample done");
    endtask

    task automatic test_trst_midshift();
        int update_pulses;
        update_pulses = 0;
        // From RTI, start an IR write of 00.
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        tick(1'b1, 1'b0, 1'b0);   // SelIR
        tick(1'b0, 1'b0, 1'b0);   // CapIR
        tick(1'b0, 1'b0, 1'b0);   // ShIR
        tick(1'b0, 1'b0, 1'b0);   // one bit shifted
        checks++; if (bus_if.tap_state !== 4'hA) begin errors++; $display("FAIL trst_pre_state got=%h exp=A", bus_if.tap_state); end
        trst = 1'b0;
        #1;
        checks++; if (bus_if.tap_state !== 4'hF) begin errors++; $display("FAIL trst_async_state got=%h exp=F", bus_if.tap_state); end
        checks++; if ({bus_if.tdo_en, bus_if.TDO} !== 2'b00) begin errors++; $display("FAIL trst_async_tdo got=%b exp=00 (en,tdo)", {bus_if.tdo_en, bus_if.TDO}); end
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL trst_async_inst got=%b exp=11", bus_if.inst); end
        #2;
        trst = 1'b1;
        // Finish what would have been the rest of the IR write sequence.
        tick(1'b0, 1'b0, 1'b0);   // RTI
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        tick(1'b1, 1'b0, 1'b0);   // SelDR
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        tick(1'b0, 1'b0, 1'b0);   // CapDR
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        tick(1'b1, 1'b0, 1'b0);   // Ex1DR
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        tick(1'b1, 1'b0, 1'b0);   // UpdDR
        if (bus_if.bsr_update === 1'b1) update_pulses++;
        checks++; if (bus_if.tap_state !== 4'h5) begin errors++; $display("FAIL trst_post_state got=%h exp=5", bus_if.tap_state); end
        checks++; if (bus_if.inst !== 2'b11) begin errors++; $display("FAIL trst_post_inst got=%b exp=11", bus_if.inst); end
        checks++; if (update_pulses != 0) begin errors++; $display("FAIL trst_update_pulses got=%0d exp=0", update_pulses); end
        $display("test_trst_midshift done");
    endtask

    initial begin
        test_reset();
        test_tlr_from_any();
        test_ir_load();
        test_bypass();
        test_bsr_sample();
        test_trst_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
